control_miscare_param: RTL and testbench
========================================

Name: control_miscare_param

Overview:
- Clocked, parametrised successor to the combinational line-follower movement logic.
- Takes an N-sensor reflective array, the circuit-mode select and the lap target, and produces motor direction codes, PWM compare values, signalling lamps and a lap count.
- Adds input synchronisation, a registered steering FSM, edge-detected and debounced finish-line counting, and a lost-line search timeout.
- Sits between the sensor pins and the PWM comparators / motor drivers.

Parameters:
- N_SENZORI, 5, sensor count; odd, at least 5; centre index C = N_SENZORI/2.
- DC_W, 12, width of the PWM compare values.
- DC_MAX, 12'h998, compare value for full speed.
- DC_CURBA, 12'h750, compare value for the slowed wheel during correction.
- DEB_CYC, 4, consecutive synchronised cycles both outer sensors must be high to register a finish line.
- TIMEOUT_CYC, 50000, maximum consecutive cycles in CAUTARE before forced stop; counter width is clog2(TIMEOUT_CYC+1).
- TURE_C1, 1, lap target for circuit 2'b01.
- TURE_C2, 10, lap target for circuit 2'b10.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-high.
- senzori, in, N_SENZORI, 1 = black line. Bit 0 is the outer-right sensor; bit N-1 is the outer-left sensor.
- circuit, in, 2:
  - 00: idle/clear
  - 01: straight-line run
  - 10: curves run
  - 11: endurance
- directie_driverA, out, 2:
  - 10: forward
  - 01: reverse
  - 00: brake
- directie_driverB, out, 2, same encoding as directie_driverA.
- factor_dc_driverA, out, DC_W, PWM compare value for driver A.
- factor_dc_driverB, out, DC_W, PWM compare value for driver B.
- semnal_dreapta, out, 1, right lamp.
- semnal_stanga, out, 1, left lamp.
- stop, out, 1, brake lamp.
- count_ture, out, 8, completed laps.
- stare, out, 2, FSM state for debug: 0 = INAINTE, 1 = CAUTARE, 2 = OPRIT.

Behaviour:
- Reset values (also asynchronous reset mid-run):
  - FSM state INAINTE, memory NIMIC.
  - directie_driverA/B = 2'b10; factor_dc_driverA/B = DC_MAX.
  - count_ture = 0; stop, semnal_dreapta, semnal_stanga = 0.
  - Synchroniser flops, debounce counter and timeout counter = 0.
- Synchronisation and latency:
  - senzori pass through a 2-flop synchroniser; all logic uses the synchronised vector s.
  - All outputs are registered.
  - A pin change reaches the outputs exactly 3 rising edges later.
- Signal groups:
  - drp = OR of s[1..C-1]; stg = OR of s[C+1..N-2].
  - semnal_dreapta = s[0]; semnal_stanga = s[N-1], both registered.
- INAINTE:
  - s[C]=0 → CAUTARE.
  - drp=1, stg=0: both directions 10, dcA = DC_CURBA, dcB = DC_MAX, memory = DREAPTA.
  - stg=1, drp=0: dcA = DC_MAX, dcB = DC_CURBA, memory = STANGA.
  - Both or neither: both dc = DC_MAX, memory unchanged.
  - stop = 0.
- CAUTARE:
  - Both dc = DC_MAX; stop = 1; timeout counter increments each cycle.
  - Memory DREAPTA: A = 01, B = 10. Memory STANGA: A = 10, B = 01.
  - Memory NIMIC: use drp/stg as above to pivot (memory loads from them); if both or neither, A = B = 10.
  - s[C]=1 → INAINTE; timeout counter cleared.
  - Counter reaching TIMEOUT_CYC → OPRIT.
- OPRIT:
  - Both directions 00, both dc = 0, stop = 1.
  - Exits to INAINTE (memory NIMIC) only when circuit==00 and s[C]=1.
- Finish detection:
  - Debounce counter increments while s[0]&s[N-1], saturating at DEB_CYC; clears otherwise.
  - Exactly one lap increment when the counter first reaches DEB_CYC.
  - Re-arms only after the counter has cleared.
  - count_ture saturates at 255.
- Lap target:
  - If the incremented count equals the target for the current circuit (01 → TURE_C1, 10 → TURE_C2), the FSM enters OPRIT on the same edge the count updates.
  - circuit 11 never stops on laps.
- circuit==00 forces count_ture to 0 every cycle. A clear coincident with a finish event wins (count = 0, no stop).
- A lap target hit in CAUTARE still goes to OPRIT. In OPRIT, laps are not counted.

Test Plan:
1. Reset asserted mid-CAUTARE with senzori=00100 → outputs immediately return to the reset values; after release, holding 00100 gives dirs 10/10 and dc 998/998 from edge 3.
2. senzori 00100 → 00110, circuit=11 → 3 edges later dcA=750, dcB=998, dirs 10/10. Then 00000 → 3 edges later stare=1, A=01, B=10, stop=1.
3. circuit=10, TIMEOUT_CYC=20, senzori held 00000 → after 20 cycles in CAUTARE stare=2, dirs 00/00, dc 0/0. Then circuit=00 plus 00100 → INAINTE.
4. circuit=10, ten pulses of 10101 lasting 6 cycles each, separated by 00100 → count_ture steps 1..10 (one per pulse), OPRIT on the 10th. A 3-cycle pulse (< DEB_CYC) → no count.
5. circuit=01, one 10101 pulse of 8 cycles → count_ture=1, stare=2.
6. circuit=11, finish debounce completes in the same cycle circuit switches to 00 → count_ture=0, no stop. Then 260 laps with circuit=11 → count saturates at 255.

Source files
------------

// File: rtl/control_miscare_param.sv
// control_miscare_param: clocked line-follower movement controller.
// Synchronises the reflective sensor array, steers with a registered FSM
// (INAINTE / CAUTARE / OPRIT), counts debounced finish-line crossings and
// stops on the lap target, on a lost-line timeout, or when circuit is cleared.
module control_miscare_param #(
  parameter int              N_SENZORI   = 5,
  parameter int              DC_W        = 12,
  parameter logic [DC_W-1:0] DC_MAX      = 12'h998,
  parameter logic [DC_W-1:0] DC_CURBA    = 12'h750,
  parameter int              DEB_CYC     = 4,
  parameter int              TIMEOUT_CYC = 50000,
  parameter int              TURE_C1     = 1,
  parameter int              TURE_C2     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SENZORI-1:0] senzori,
  input  logic [1:0]           circuit,
  output logic [1:0]           directie_driverA,
  output logic [1:0]           directie_driverB,
  output logic [DC_W-1:0]      factor_dc_driverA,
  output logic [DC_W-1:0]      factor_dc_driverB,
  output logic                 semnal_dreapta,
  output logic                 semnal_stanga,
  output logic                 stop,
  output logic [7:0]           count_ture,
  output logic [1:0]           stare
);

  localparam int C     = N_SENZORI / 2;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int DEB_W = $clog2(DEB_CYC + 1);

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_BRAKE = 2'b00;

  typedef enum logic [1:0] {
    INAINTE = 2'd0,
    CAUTARE = 2'd1,
    OPRIT   = 2'd2
  } stare_t;

  typedef enum logic [1:0] {
    NIMIC   = 2'd0,
    DREAPTA = 2'd1,
    STANGA  = 2'd2
  } mem_t;

  logic [N_SENZORI-1:0] r_sync1;
  logic [N_SENZORI-1:0] r_sync2;
  logic [N_SENZORI-1:0] w_s;

  stare_t           r_stare;
  stare_t           w_stareNext;
  mem_t             r_mem;
  mem_t             w_memNext;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmoNext;
  logic [TMO_W-1:0] w_tmoInc;

  logic [DEB_W-1:0] r_deb;
  logic [DEB_W-1:0] w_debNext;
  logic [7:0]       r_count;
  logic [7:0]       w_countNext;
  logic [7:0]       w_countInc;
  logic             w_both;
  logic             w_finishEvt;
  logic             w_targetHit;

  logic             w_drp;
  logic             w_stg;

  logic [1:0]       r_dirA, r_dirB, w_dirANext, w_dirBNext;
  logic [DC_W-1:0]  r_dcA, r_dcB, w_dcANext, w_dcBNext;
  logic             r_stop, w_stopNext;
  logic             r_semDr, r_semSt;

  assign w_s = r_sync2;

  // Two-flop synchroniser so that asynchronous sensor pins never reach the FSM directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= senzori;
      r_sync2 <= r_sync1;
    end
  end

  // Right group is the sensors between the outer-right one and the centre, left group likewise
  always_comb begin
    w_drp = 1'b0;
    w_stg = 1'b0;
    for (int i = 1; i < C; i++) w_drp = w_drp | w_s[i];
    for (int i = C + 1; i < N_SENZORI - 1; i++) w_stg = w_stg | w_s[i];
  end

  // Finish line: both outer sensors held for DEB_CYC cycles; one event per crossing, ignored while stopped
  always_comb begin
    w_both     = w_s[0] & w_s[N_SENZORI-1];
    w_countInc = (r_count == 8'd255) ? 8'd255 : r_count + 8'd1;
    if (!w_both)
      w_debNext = '0;
    else if (r_deb == DEB_W'(DEB_CYC))
      w_debNext = r_deb;
    else
      w_debNext = r_deb + DEB_W'(1);
    w_finishEvt = w_both && (r_deb == DEB_W'(DEB_CYC - 1)) && (r_stare != OPRIT);
    w_targetHit = w_finishEvt &&
                  (((circuit == 2'b01) && (w_countInc == 8'(TURE_C1))) ||
                   ((circuit == 2'b10) && (w_countInc == 8'(TURE_C2))));
    if (circuit == 2'b00)
      w_countNext = 8'd0;
    else if (w_finishEvt)
      w_countNext = w_countInc;
    else
      w_countNext = r_count;
  end

  // Debounce counter and lap counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb   <= '0;
      r_count <= 8'd0;
    end else begin
      r_deb   <= w_debNext;
      r_count <= w_countNext;
    end
  end

  // Steering next-state logic: memory remembers the last side the line drifted to
  always_comb begin
    w_stareNext = r_stare;
    w_memNext   = r_mem;
    w_tmoInc    = r_tmo + TMO_W'(1);
    w_tmoNext   = '0;
    case (r_stare)
      INAINTE: begin
        if (w_drp && !w_stg)
          w_memNext = DREAPTA;
        else if (w_stg && !w_drp)
          w_memNext = STANGA;
        if (!w_s[C])
          w_stareNext = CAUTARE;
      end
      CAUTARE: begin
        if (r_mem == NIMIC) begin
          if (w_drp && !w_stg)
            w_memNext = DREAPTA;
          else if (w_stg && !w_drp)
            w_memNext = STANGA;
        end
        if (w_s[C])
          w_stareNext = INAINTE;
        else if (w_tmoInc == TMO_W'(TIMEOUT_CYC))
          w_stareNext = OPRIT;
        else
          w_tmoNext = w_tmoInc;
      end
      OPRIT: begin
        if ((circuit == 2'b00) && w_s[C]) begin
          w_stareNext = INAINTE;
          w_memNext   = NIMIC;
        end
      end
      default: begin
        w_stareNext = INAINTE;
        w_memNext   = NIMIC;
      end
    endcase
    if (w_targetHit)
      w_stareNext = OPRIT;
    if (w_stareNext != CAUTARE)
      w_tmoNext = '0;
  end

  // FSM state, side memory and lost-line timeout registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stare <= INAINTE;
      r_mem   <= NIMIC;
      r_tmo   <= '0;
    end else begin
      r_stare <= w_stareNext;
      r_mem   <= w_memNext;
      r_tmo   <= w_tmoNext;
    end
  end

  // Motor commands follow the state being entered so they change on the same edge as stare
  always_comb begin
    w_dirANext = DIR_FWD;
    w_dirBNext = DIR_FWD;
    w_dcANext  = DC_MAX;
    w_dcBNext  = DC_MAX;
    w_stopNext = 1'b0;
    case (w_stareNext)
      INAINTE: begin
        if (w_drp && !w_stg)
          w_dcANext = DC_CURBA;
        else if (w_stg && !w_drp)
          w_dcBNext = DC_CURBA;
      end
      CAUTARE: begin
        w_stopNext = 1'b1;
        if (w_memNext == DREAPTA)
          w_dirANext = DIR_REV;
        else if (w_memNext == STANGA)
          w_dirBNext = DIR_REV;
      end
      OPRIT: begin
        w_dirANext = DIR_BRAKE;
        w_dirBNext = DIR_BRAKE;
        w_dcANext  = '0;
        w_dcBNext  = '0;
        w_stopNext = 1'b1;
      end
      default: begin
        w_stopNext = 1'b0;
      end
    endcase
  end

  // Registered motor, lamp outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dirA  <= DIR_FWD;
      r_dirB  <= DIR_FWD;
      r_dcA   <= DC_MAX;
      r_dcB   <= DC_MAX;
      r_stop  <= 1'b0;
      r_semDr <= 1'b0;
      r_semSt <= 1'b0;
    end else begin
      r_dirA  <= w_dirANext;
      r_dirB  <= w_dirBNext;
      r_dcA   <= w_dcANext;
      r_dcB   <= w_dcBNext;
      r_stop  <= w_stopNext;
      r_semDr <= w_s[0];
      r_semSt <= w_s[N_SENZORI-1];
    end
  end

  assign directie_driverA  = r_dirA;
  assign directie_driverB  = r_dirB;
  assign factor_dc_driverA = r_dcA;
  assign factor_dc_driverB = r_dcB;
  assign semnal_dreapta    = r_semDr;
  assign semnal_stanga     = r_semSt;
  assign stop              = r_stop;
  assign count_ture        = r_count;
  assign stare             = r_stare;

endmodule

// File: tb/tb_control_miscare_param.sv
// tb_control_miscare_param: directed vector table for steering/timeout plus
// hand-written sequences for reset, lap counting, lap target and saturation.
module tb_control_miscare_param;

  logic        clk;
  logic        reset;
  logic [4:0]  senzori;
  logic [1:0]  circuit;
  logic [1:0]  directie_driverA;
  logic [1:0]  directie_driverB;
  logic [11:0] factor_dc_driverA;
  logic [11:0] factor_dc_driverB;
  logic        semnal_dreapta;
  logic        semnal_stanga;
  logic        stop;
  logic [7:0]  count_ture;
  logic [1:0]  stare;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  sen;
    logic [1:0]  circ;
    int          cycles;
    logic [1:0]  eDirA;
    logic [1:0]  eDirB;
    logic [11:0] eDcA;
    logic [11:0] eDcB;
    logic        eStop;
    logic        eSd;
    logic        eSs;
    logic [7:0]  eCnt;
    logic [1:0]  eStare;
  } vec_t;

  vec_t vecs[13];

  control_miscare_param #(.TIMEOUT_CYC(20)) dut (
    .clk               (clk),
    .reset             (reset),
    .senzori           (senzori),
    .circuit           (circuit),
    .directie_driverA  (directie_driverA),
    .directie_driverB  (directie_driverB),
    .factor_dc_driverA (factor_dc_driverA),
    .factor_dc_driverB (factor_dc_driverB),
    .semnal_dreapta    (semnal_dreapta),
    .semnal_stanga     (semnal_stanga),
    .stop              (stop),
    .count_ture        (count_ture),
    .stare             (stare)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal({tag, " dirA"},  32'(directie_driverA),  32'(v.eDirA));
    checkVal({tag, " dirB"},  32'(directie_driverB),  32'(v.eDirB));
    checkVal({tag, " dcA"},   32'(factor_dc_driverA), 32'(v.eDcA));
    checkVal({tag, " dcB"},   32'(factor_dc_driverB), 32'(v.eDcB));
    checkVal({tag, " stop"},  32'(stop),              32'(v.eStop));
    checkVal({tag, " semDr"}, 32'(semnal_dreapta),    32'(v.eSd));
    checkVal({tag, " semSt"}, 32'(semnal_stanga),     32'(v.eSs));
    checkVal({tag, " count"}, 32'(count_ture),        32'(v.eCnt));
    checkVal({tag, " stare"}, 32'(stare),             32'(v.eStare));
  endtask

  task automatic applyStimulus(input logic [4:0] sen, input logic [1:0] circ, input int cycles);
    senzori = sen;
    circuit = circ;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Hard time limit so the bench always terminates
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;
    vecs[0]  = '{5'b00100, 2'b11,  3, 2'b10, 2'b10, 12'h998, 12'h998, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
    vecs[1]  = '{5'b00110, 2'b11,  3, 2'b10, 2'b10, 12'h750, 12'h998, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
    vecs[2]  = '{5'b01100, 2'b11,  3, 2'b10, 2'b10, 12'h998, 12'h750, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
    vecs[3]  = '{5'b00000, 2'b11,  3, 2'b10, 2'b01, 12'h998, 12'h998, 1'b1, 1'b0, 1'b0, 8'd0, 2'd1};
    vecs[4]  = '{5'b00100, 2'b11,  3, 2'b10, 2'b10, 12'h998, 12'h998, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
    vecs[5]  = '{5'b00010, 2'b11,  3, 2'b01, 2'b10, 12'h998, 12'h998, 1'b1, 1'b0, 1'b0, 8'd0, 2'd1};
    vecs[6]  = '{5'b00101, 2'b11,  3, 2'b10, 2'b10, 12'h998, 12'h998, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0};
    vecs[7]  = '{5'b10100, 2'b11,  3, 2'b10, 2'b10, 12'h998, 12'h998, 1'b0, 1'b0, 1'b1, 8'd0, 2'd0};
    vecs[8]  = '{5'b00000, 2'b10,  3, 2'b01, 2'b10, 12'h998, 12'h998, 1'b1, 1'b0, 1'b0, 8'd0, 2'd1};
    vecs[9]  = '{5'b00000, 2'b10, 19, 2'b01, 2'b10, 12'h998, 12'h998, 1'b1, 1'b0, 1'b0, 8'd0, 2'd1};
    vecs[10] = '{5'b00000, 2'b10,  1, 2'b00, 2'b00, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0, 8'd0, 2'd2};
    vecs[11] = '{5'b00100, 2'b10,  3, 2'b00, 2'b00, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0, 8'd0, 2'd2};
    vecs[12] = '{5'b00100, 2'b00,  1, 2'b10, 2'b10, 12'h998, 12'h998, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
    rv       = '{5'b00100, 2'b11,  0, 2'b10, 2'b10, 12'h998, 12'h998, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};

    reset   = 1'b1;
    senzori = 5'b00100;
    circuit = 2'b11;
    #1;
    checkOutput("reset", rv);
    doReset();

    // Reset asserted while searching for the line
    applyStimulus(5'b00000, 2'b11, 5);
    checkVal("precaut stare", 32'(stare), 32'd1);
    checkVal("precaut stop",  32'(stop),  32'd1);
    senzori = 5'b00100;
    reset   = 1'b1;
    #1;
    checkOutput("midreset", rv);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(5'b00100, 2'b11, 3);
    checkOutput("postreset", rv);

    // Steering, search and timeout table
    senzori = 5'b00100;
    circuit = 2'b11;
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].sen, vecs[i].circ, vecs[i].cycles);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Curves run: short pulse ignored, ten laps then stop
    senzori = 5'b00100;
    circuit = 2'b10;
    doReset();
    applyStimulus(5'b00100, 2'b10, 3);
    applyStimulus(5'b10101, 2'b10, 3);
    applyStimulus(5'b00100, 2'b10, 5);
    checkVal("shortpulse count", 32'(count_ture), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(5'b10101, 2'b10, 6);
      applyStimulus(5'b00100, 2'b10, 4);
      checkVal($sformatf("c2 lap%0d count", i), 32'(count_ture), 32'(i));
      checkVal($sformatf("c2 lap%0d stare", i), 32'(stare), (i == 10) ? 32'd2 : 32'd0);
    end
    checkVal("c2 stop dirA", 32'(directie_driverA), 32'd0);
    checkVal("c2 stop dcB",  32'(factor_dc_driverB), 32'd0);

    // Straight run: one long pulse reaches the target
    senzori = 5'b00100;
    circuit = 2'b01;
    doReset();
    applyStimulus(5'b00100, 2'b01, 3);
    applyStimulus(5'b10101, 2'b01, 8);
    checkVal("c1 count", 32'(count_ture), 32'd1);
    checkVal("c1 stare", 32'(stare), 32'd2);
    applyStimulus(5'b00100, 2'b01, 3);
    checkVal("c1 hold count", 32'(count_ture), 32'd1);
    checkVal("c1 hold stop",  32'(stop), 32'd1);

    // Endurance: clear coincident with finish event, then saturation
    senzori = 5'b00100;
    circuit = 2'b11;
    doReset();
    applyStimulus(5'b00100, 2'b11, 3);
    applyStimulus(5'b10101, 2'b11, 6);
    applyStimulus(5'b00100, 2'b11, 4);
    checkVal("c3 first count", 32'(count_ture), 32'd1);
    applyStimulus(5'b10101, 2'b11, 5);
    applyStimulus(5'b10101, 2'b00, 1);
    checkVal("clear count", 32'(count_ture), 32'd0);
    checkVal("clear stare", 32'(stare), 32'd0);
    checkVal("clear stop",  32'(stop), 32'd0);
    applyStimulus(5'b10101, 2'b11, 2);
    checkVal("clear norearm", 32'(count_ture), 32'd0);
    applyStimulus(5'b00100, 2'b11, 4);
    for (int i = 0; i < 260; i++) begin
      applyStimulus(5'b10101, 2'b11, 6);
      applyStimulus(5'b00100, 2'b11, 4);
      if (i == 99) checkVal("c3 count100", 32'(count_ture), 32'd100);
    end
    checkVal("sat count", 32'(count_ture), 32'd255);
    checkVal("sat stare", 32'(stare), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
